// File: rtl/cla_pkg.sv
// Shared types for the two-stage carry-lookahead adder.
// Holds the group width, the group G/P pair and the per-group stage-1 payload.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } grp_gp_t;

  typedef struct packed {
    logic [GROUP_W-1:0] g_bit;
    logic [GROUP_W-1:0] p_bit;
    grp_gp_t            gp;
    logic [GROUP_W-1:0] sum0;
    logic [GROUP_W-1:0] sum1;
  } s1_grp_t;

endpackage

// File: rtl/cla_group_4.sv
// One 4-bit lookahead group: bit G/P, group G/P and sums for
// both possible carry-ins, all combinational.
module cla_group_4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_a,
  input  logic [GROUP_W-1:0] i_b,
  output s1_grp_t            o_grp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c0;
  logic [GROUP_W:0]   c1;

  always_comb begin
    g     = i_a & i_b;
    p     = i_a ^ i_b;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < GROUP_W; i++) begin
      c0[i+1] = g[i] | (p[i] & c0[i]);
      c1[i+1] = g[i] | (p[i] & c1[i]);
    end
    o_grp.g_bit = g;
    o_grp.p_bit = p;
    o_grp.gp.g  = g[3] | (p[3] & g[2]) |
                  (p[3] & p[2] & g[1]) |
                  (p[3] & p[2] & p[1] & g[0]);
    o_grp.gp.p  = &p;
    o_grp.sum0  = p ^ c0[GROUP_W-1:0];
    o_grp.sum1  = p ^ c1[GROUP_W-1:0];
  end

endmodule

// File: rtl/cla_adder_pipelined.sv
// Two-stage carry-lookahead adder with valid/ready on both sides.
// Define CLA_SUBTRACT_EN to add i_sub / o_overflow.
module cla_adder_pipelined
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
`ifdef CLA_SUBTRACT_EN
  input  logic             i_sub,
  output logic             o_overflow,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int NUM_GROUPS = WIDTH / GROUP;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  s1_grp_t [NUM_GROUPS-1:0] grp_w;
  s1_grp_t [NUM_GROUPS-1:0] s1_grp_d, s1_grp_q;
  logic s1_cin_d, s1_cin_q;
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic [WIDTH:0] res_d, res_q;
  logic ovf_d, ovf_q;

  logic s1_load, s2_load;
  logic [NUM_GROUPS:0] gc;
  logic [WIDTH-1:0] sum_w;
  logic acc, pp, c_msb_in;
  logic unused_s1;

  // Subtraction folds into the operand/carry before G/P are formed.
  always_comb begin
    b_eff   = i_add2;
    cin_eff = i_carry;
`ifdef CLA_SUBTRACT_EN
    if (i_sub) begin
      b_eff   = ~i_add2;
      cin_eff = 1'b1;
    end
`endif
  end

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
    cla_group_4 u_grp (
      .i_a   (i_add1[gi*GROUP_W +: GROUP_W]),
      .i_b   (b_eff[gi*GROUP_W +: GROUP_W]),
      .o_grp (grp_w[gi])
    );
  end

  always_comb begin
    s2_load    = !s2_valid_q || i_ready;
    s1_load    = !s1_valid_q || s2_load;
    o_ready    = s1_load;
    s1_valid_d = s1_load ? i_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s1_grp_d   = s1_grp_q;
    s1_cin_d   = s1_cin_q;
    if (s1_load && i_valid) begin
      s1_grp_d = grp_w;
      s1_cin_d = cin_eff;
    end
  end

  // Each group carry is a flat OR of G terms gated by downstream P.
  always_comb begin
    gc    = '0;
    gc[0] = s1_cin_q;
    acc   = 1'b0;
    pp    = 1'b0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      acc = s1_grp_q[k].gp.g;
      pp  = s1_grp_q[k].gp.p;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & s1_grp_q[j].gp.g);
        pp  = pp & s1_grp_q[j].gp.p;
      end
      gc[k+1] = acc | (pp & s1_cin_q);
    end
    sum_w     = '0;
    unused_s1 = 1'b0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      sum_w[k*GROUP_W +: GROUP_W] =
        gc[k] ? s1_grp_q[k].sum1 : s1_grp_q[k].sum0;
      unused_s1 = unused_s1 ^
        (^{s1_grp_q[k].g_bit, s1_grp_q[k].p_bit});
    end
    c_msb_in = sum_w[WIDTH-1] ^
      s1_grp_q[NUM_GROUPS-1].p_bit[GROUP_W-1];
    res_d = res_q;
    ovf_d = ovf_q;
    if (s2_load && s1_valid_q) begin
      res_d = {gc[NUM_GROUPS], sum_w};
      ovf_d = c_msb_in ^ gc[NUM_GROUPS];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    s1_grp_q <= s1_grp_d;
    s1_cin_q <= s1_cin_d;
  end

  assign o_valid  = s2_valid_q;
  assign o_result = res_q;
`ifdef CLA_SUBTRACT_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Bench for cla_adder_pipelined: directed vectors, handshake corners,
// reset cases and a random sweep at several widths.
module tb_cla_adder_pipelined;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vin, rdy_in, cin, ordy, ovld;
  logic [W-1:0] a, b;
  logic [W:0] res;
`ifdef CLA_SUBTRACT_EN
  logic sub, unused_ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];
  logic sweep_go = 1'b0;
  logic [2:0] sw_done = '0;

  cla_adder_pipelined #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(ordy),
    .i_add1(a), .i_add2(b), .i_carry(cin),
`ifdef CLA_SUBTRACT_EN
    .i_sub(sub), .o_overflow(unused_ovf),
`endif
    .o_valid(ovld), .i_ready(rdy_in), .o_result(res)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, settle, record accepted input.
  task automatic cyc(input logic rs, input logic v,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic c, input logic r,
                     input logic [W:0] e);
    @(negedge clk);
    rst = rs; vin = v; a = x; b = y; cin = c; rdy_in = r;
    #1;
    if (v && ordy && !rs) sb.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++)
      cyc(0, 0, '0, '0, 0, 1, '0);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) cyc(0, 0, '0, '0, 0, 1, '0);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && ovld && rdy_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", res);
      end else begin
        chk("sb_result", 64'(res), 64'(sb.pop_front()));
      end
    end
  end

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    logic [W:0]   e;
  } vec_t;
  vec_t tv[8];

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int SW = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;
    logic sv, sr, sc, s_ordy, s_ovld;
    logic [SW-1:0] sa, sbb;
    logic [SW:0] sres, ex;
    logic [SW:0] q[$];
`ifdef CLA_SUBTRACT_EN
    logic unused_sovf;
`endif

    cla_adder_pipelined #(.WIDTH(SW)) u_sw (
      .i_clk(clk), .i_rst(rst), .i_valid(sv), .o_ready(s_ordy),
      .i_add1(sa), .i_add2(sbb), .i_carry(sc),
`ifdef CLA_SUBTRACT_EN
      .i_sub(1'b0), .o_overflow(unused_sovf),
`endif
      .o_valid(s_ovld), .i_ready(sr), .o_result(sres)
    );

    initial begin
      sv = 0; sr = 1; sc = 0; sa = '0; sbb = '0;
      wait (sweep_go);
      for (int n = 0; n < 330; n++) begin
        @(negedge clk);
        sv  = (n < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        sr  = (n < 300) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        sa  = SW'($urandom);
        sbb = SW'($urandom);
        sc  = 1'($urandom_range(0, 1));
        #1;
        if (sr && s_ovld) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_w%0d_extra: got %0h expected none",
                     SW, sres);
          end else begin
            ex = q.pop_front();
            chk($sformatf("sweep_w%0d", SW), 64'(sres), 64'(ex));
          end
        end
        if (sv && s_ordy)
          q.push_back({1'b0, sa} + {1'b0, sbb} + (SW + 1)'(sc));
      end
      chk($sformatf("sweep_w%0d_left", SW), 64'(q.size()), 64'd0);
      sw_done[gi] = 1'b1;
    end
  end

`ifdef CLA_SUBTRACT_EN
  logic s8_v, s8_sub, s8_c, s8_ordy, s8_ovld, s8_ovf;
  logic [7:0] s8_a, s8_b;
  logic [8:0] s8_res;

  cla_adder_pipelined #(.WIDTH(8)) u_s8 (
    .i_clk(clk), .i_rst(rst), .i_valid(s8_v), .o_ready(s8_ordy),
    .i_add1(s8_a), .i_add2(s8_b), .i_carry(s8_c),
    .i_sub(s8_sub), .o_overflow(s8_ovf),
    .o_valid(s8_ovld), .i_ready(1'b1), .o_result(s8_res)
  );
`endif

  initial begin
    rst = 1; vin = 0; rdy_in = 1; cin = 0; a = '0; b = '0;
`ifdef CLA_SUBTRACT_EN
    sub = 0; s8_v = 0; s8_sub = 0; s8_c = 0; s8_a = '0; s8_b = '0;
`endif
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    tv[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tv[2] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    tv[3] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    tv[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    tv[5] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    tv[6] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    tv[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF};

    cyc(1, 0, '0, '0, 0, 1, '0);
    cyc(1, 1, 16'd5, 16'd6, 0, 1, 17'd11);
    chk("rst_o_valid", 64'(ovld), 64'd0);
    chk("rst_o_result", 64'(res), 64'd0);
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("rdy_after_rst", 64'(ordy), 64'd1);
    for (int n = 0; n < 3; n++) begin
      cyc(0, 0, '0, '0, 0, 1, '0);
      chk("rst_input_dropped", 64'(ovld), 64'd0);
    end

    cyc(0, 1, 16'hFFFF, 16'h0001, 0, 1, 17'h10000);
    chk("lat_accept", 64'(ordy), 64'd1);
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("lat_cycle1", 64'(ovld), 64'd0);
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("lat_cycle2", 64'(ovld), 64'd1);
    chk("lat_result", 64'(res), 64'h10000);
    drain();

    cyc(0, 1, 16'd1, 16'd2, 0, 1, 17'd3);
    cyc(0, 1, 16'd3, 16'd4, 0, 1, 17'd7);
    cyc(0, 1, 16'd5, 16'd6, 0, 1, 17'd11);
    chk("b2b_r0", 64'({ovld, res}), 64'({1'b1, 17'd3}));
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("b2b_r1", 64'({ovld, res}), 64'({1'b1, 17'd7}));
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("b2b_r2", 64'({ovld, res}), 64'({1'b1, 17'd11}));
    drain();

    for (int i = 0; i < 8; i++)
      cyc(0, 1, tv[i].x, tv[i].y, tv[i].c, 1, tv[i].e);
    drain();

    cyc(0, 1, 16'd1, 16'd2, 0, 0, 17'd3);
    chk("bp_rdy0", 64'(ordy), 64'd1);
    cyc(0, 1, 16'd3, 16'd4, 0, 0, 17'd7);
    chk("bp_rdy1", 64'(ordy), 64'd1);
    for (int n = 0; n < 2; n++) begin
      cyc(0, 1, 16'd5, 16'd6, 0, 0, 17'd11);
      chk("bp_rdy_low", 64'(ordy), 64'd0);
      chk("bp_hold", 64'({ovld, res}), 64'({1'b1, 17'd3}));
    end
    cyc(0, 1, 16'd5, 16'd6, 0, 1, 17'd11);
    chk("bp_release", 64'(ordy), 64'd1);
    cyc(0, 1, 16'd7, 16'd8, 0, 1, 17'd15);
    drain();

    cyc(0, 1, 16'd100, 16'd1, 0, 0, 17'd101);
    cyc(0, 1, 16'd200, 16'd2, 0, 0, 17'd202);
    cyc(0, 0, '0, '0, 0, 0, '0);
    chk("full_rdy", 64'(ordy), 64'd0);
    cyc(1, 1, 16'd300, 16'd3, 0, 1, '0);
    sb.delete();
    cyc(0, 0, '0, '0, 0, 1, '0);
    chk("midrst_valid", 64'(ovld), 64'd0);
    chk("midrst_rdy", 64'(ordy), 64'd1);
    for (int n = 0; n < 4; n++) begin
      cyc(0, 0, '0, '0, 0, 1, '0);
      chk("midrst_stale", 64'(ovld), 64'd0);
    end

`ifdef CLA_SUBTRACT_EN
    @(negedge clk);
    s8_v = 1; s8_sub = 1; s8_c = 0; s8_a = 8'h80; s8_b = 8'h01;
    #1 chk("sub_accept", 64'(s8_ordy), 64'd1);
    @(negedge clk);
    s8_c = 1; s8_a = 8'h05; s8_b = 8'h03;
    @(negedge clk);
    s8_v = 0;
    #1;
    chk("sub_80_01", 64'({s8_ovld, s8_res}), 64'({1'b1, 9'h17F}));
    chk("sub_80_01_ovf", 64'(s8_ovf), 64'd1);
    @(negedge clk);
    #1;
    chk("sub_05_03", 64'({s8_ovld, s8_res}), 64'({1'b1, 9'h102}));
    chk("sub_05_03_ovf", 64'(s8_ovf), 64'd0);
`endif

    sweep_go = 1'b1;
    fork
      wait (&sw_done);
      repeat (500) @(posedge clk);
    join_any
    disable fork;
    chk("sweep_done", 64'(sw_done), 64'h7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_adder_pipelined.md
CLA_ADDER_PIPELINED -- requirements
Module: cla_adder_pipelined

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter GROUP, default 4: bits per lookahead group; fixed at 4, so NUM_GROUPS = WIDTH/4.
REQ-003 i_clk  in  1: single clock; all state SHALL update on the rising edge only.
REQ-004 i_rst  in  1: synchronous, active-high reset.
REQ-005 i_valid  in  1: the input operands are valid this cycle.
REQ-006 o_ready  out  1: the block accepts the input this cycle.
REQ-007 i_add1, i_add2  in  WIDTH: unsigned operands.
REQ-008 i_carry  in  1: carry-in to bit 0.
REQ-009 o_valid  out  1: the result is valid.
REQ-010 i_ready  in  1: the downstream consumer accepts the result.
REQ-011 o_result  out  WIDTH+1: result as {carry-out, sum}.

Function
REQ-012 A transfer SHALL occur on an input edge only when i_valid && o_ready are both high, and on an output edge only when o_valid && i_ready are both high.
REQ-013 Stage 1 SHALL register, per 4-bit group:
- bit generate G_i = a&b and bit propagate P_i = a^b;
- group G/P;
- per-group sums for carry-in 0 and for carry-in 1;
- the effective carry-in.
REQ-014 Stage 2 SHALL derive group carries with lookahead from the registered group G/P and the carry-in, select each group's sum, and register o_result.
REQ-015 Latency SHALL be exactly 2 cycles from accepted input to o_valid when there is no backpressure.
REQ-016 Throughput SHALL be one result per cycle while i_ready is held high.
REQ-017 Stage 2 SHALL load when !s2_valid || i_ready; stage 1 SHALL load when !s1_valid || (stage 2 loads).
REQ-018 o_ready SHALL equal !s1_valid || (stage-2 load condition) and SHALL be purely combinational from state and i_ready.
REQ-019 While o_valid && !i_ready, o_result and o_valid SHALL hold stable.
REQ-020 With both stages full and i_ready low, o_ready SHALL be 0 and no input SHALL be lost or duplicated.
REQ-021 Wrap-around: the sum SHALL be modulo 2^WIDTH, with the carry-out in o_result[WIDTH].

Reset
REQ-022 On i_rst, s1_valid, s2_valid and o_valid SHALL clear to 0 and o_result SHALL clear to 0 on the next edge.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight data.
REQ-024 The cycle after reset deasserts, o_ready SHALL be 1.
REQ-025 An input presented on a cycle with i_rst high SHALL NOT be captured.

Configuration
REQ-026 Macro CLA_SUBTRACT_EN, when defined, SHALL add these ports, carried through stage 1 with the operands:
- i_sub  in  1: subtract request;
- o_overflow  out  1: signed overflow of the result.
REQ-027 With CLA_SUBTRACT_EN defined and i_sub high, the operation SHALL be i_add1 + ~i_add2 + 1, and i_carry SHALL be ignored.
REQ-028 With CLA_SUBTRACT_EN defined, o_overflow SHALL be the carry into the MSB XOR the carry out of the MSB, and SHALL reset to 0.
REQ-029 Without CLA_SUBTRACT_EN, neither port SHALL exist and the block SHALL only add.

Structure
REQ-030 Shared package cla_pkg SHALL hold:
- the GROUP_W = 4 constant;
- the group G/P struct typedef;
- the stage-1 payload typedef.
REQ-031 One sub-module, cla_group_4, SHALL compute group G/P and the dual sums for one 4-bit group combinationally; it SHALL be instantiated NUM_GROUPS times.

Verification
REQ-032 WIDTH=16, 0xFFFF + 0x0001, i_carry=0 -> o_result=0x1_0000 exactly 2 cycles after acceptance.
REQ-033 Back-to-back inputs 1+2, 3+4, 5+6 with i_ready=1 -> results 3, 7, 11 on three consecutive cycles.
REQ-034 Hold i_ready=0 for 4 cycles while streaming inputs:
- o_ready drops after two accepts;
- o_result holds 3;
- after release, all results appear in order with none lost.
REQ-035 Assert i_rst with both stages full -> o_valid=0 next cycle, o_ready=1 after release, stale results never emerge.
REQ-036 CLA_SUBTRACT_EN, WIDTH=8, i_sub=1:
- 0x80 - 0x01 -> sum 0x7F, o_overflow=1;
- 0x05 - 0x03 -> sum 0x02, carry=1, o_overflow=0.
REQ-037 A random sweep at WIDTH=4, 8 and 32 SHALL match a reference a+b+cin model with randomised i_valid and i_ready.
